// File: rtl/word_gen_dbuf.sv
// Double-buffered mask word generator.
// One bank takes configuration bytes while the other generates words.
module word_gen_dbuf #(
  parameter int CHAR_BITS  = 7,
  parameter int RANGES_MAX = 8,
  parameter int CHARS_MAX  = (CHAR_BITS == 7 ? 96 : 224)
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [7:0]                       din,
  input  logic [15:0]                      inpkt_id,
  input  logic                             wr_conf_en,
  output logic                             conf_full,
  input  logic                             rd_en,
  output logic                             empty,
  output logic [RANGES_MAX*CHAR_BITS-1:0]  dout,
  output logic [$clog2(RANGES_MAX+1)-1:0]  word_len,
  output logic [15:0]                      pkt_id,
  output logic [31:0]                      gen_id,
  output logic                             gen_end,
  output logic                             err_word_gen_conf
);

  localparam int LW = $clog2(RANGES_MAX + 1);
  localparam int RW = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;
  localparam int CW = (CHARS_MAX > 1) ? $clog2(CHARS_MAX) : 1;

  typedef enum logic [3:0] {
    C_NUM_RANGES, C_NUM_CHARS, C_START_IDX, C_CHARS,
    C_NUM_GEN0, C_NUM_GEN1, C_NUM_GEN2, C_NUM_GEN3,
    C_MAGIC, C_ERROR
  } cstate_t;

  typedef enum logic [1:0] {G_IDLE, G_LOAD, G_GEN} gstate_t;

  cstate_t cstate;
  gstate_t gstate;

  logic [CHAR_BITS-1:0] mem [2][RANGES_MAX][CHARS_MAX];
  logic [7:0]  nc  [2][RANGES_MAX];
  logic [7:0]  si  [2][RANGES_MAX];
  logic [LW-1:0] nr [2];
  logic [31:0] ng  [2];
  logic [15:0] pid [2];

  logic [1:0] ready, set_mask, clr_mask, rdy_now;
  logic wr_bank, rd_bank;
  logic [RW-1:0] rcnt;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] idx [RANGES_MAX];
  logic [CW-1:0] nxt_idx [RANGES_MAX];
  logic [31:0] gen_cnt;
  logic acc, set_rdy, clr_rdy, last, all_max, carry;

  assign acc     = wr_conf_en & ~conf_full;
  assign set_rdy = acc && cstate == C_MAGIC && din == 8'hBB;
  assign clr_rdy = gstate == G_GEN && rd_en && last;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[wr_bank] = set_rdy;
    clr_mask[rd_bank] = clr_rdy;
  end

  // a bank completing this cycle can be picked up without an idle bubble
  assign rdy_now = ready | set_mask;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ready <= '0;
    else          ready <= (ready | set_mask) & ~clr_mask;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cstate  <= C_NUM_RANGES;
      wr_bank <= 1'b0;
      rcnt    <= '0;
      ccnt    <= '0;
      for (int b = 0; b < 2; b++) begin
        nr[b]  <= '0;
        ng[b]  <= '0;
        pid[b] <= '0;
        for (int r = 0; r < RANGES_MAX; r++) begin
          nc[b][r] <= '0;
          si[b][r] <= '0;
        end
      end
    end else if (acc) begin
      unique case (cstate)
        C_NUM_RANGES:
          if (din == 8'd0 || din > 8'(RANGES_MAX)) begin
            cstate <= C_ERROR;
          end else begin
            nr[wr_bank]  <= LW'(din);
            pid[wr_bank] <= inpkt_id;
            rcnt         <= '0;
            cstate       <= C_NUM_CHARS;
          end
        C_NUM_CHARS:
          if (din == 8'd0 || din > 8'(CHARS_MAX)) begin
            cstate <= C_ERROR;
          end else begin
            nc[wr_bank][rcnt] <= din;
            cstate            <= C_START_IDX;
          end
        C_START_IDX:
          if (din >= nc[wr_bank][rcnt]) begin
            cstate <= C_ERROR;
          end else begin
            si[wr_bank][rcnt] <= din;
            ccnt              <= '0;
            cstate            <= C_CHARS;
          end
        C_CHARS:
          if (ccnt == CW'(nc[wr_bank][rcnt] - 8'd1)) begin
            if (LW'(rcnt) + LW'(1) == nr[wr_bank]) begin
              cstate <= C_NUM_GEN0;
            end else begin
              rcnt   <= rcnt + 1'b1;
              cstate <= C_NUM_CHARS;
            end
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        C_NUM_GEN0: begin
          ng[wr_bank][7:0] <= din;
          cstate <= C_NUM_GEN1;
        end
        C_NUM_GEN1: begin
          ng[wr_bank][15:8] <= din;
          cstate <= C_NUM_GEN2;
        end
        C_NUM_GEN2: begin
          ng[wr_bank][23:16] <= din;
          cstate <= C_NUM_GEN3;
        end
        C_NUM_GEN3: begin
          ng[wr_bank][31:24] <= din;
          cstate <= C_MAGIC;
        end
        C_MAGIC:
          if (din == 8'hBB) begin
            wr_bank <= ~wr_bank;
            cstate  <= C_NUM_RANGES;
          end else begin
            cstate <= C_ERROR;
          end
        C_ERROR: cstate <= C_ERROR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (acc && cstate == C_CHARS)
      mem[wr_bank][rcnt][ccnt] <= din[CHAR_BITS-1:0];
  end

  // odometer step: last active range is least significant
  always_comb begin
    carry   = 1'b1;
    all_max = 1'b1;
    for (int r = RANGES_MAX - 1; r >= 0; r--) begin
      nxt_idx[r] = idx[r];
      if (LW'(r) < nr[rd_bank]) begin
        if (idx[r] == CW'(nc[rd_bank][r] - 8'd1)) begin
          if (carry) nxt_idx[r] = '0;
        end else begin
          all_max = 1'b0;
          if (carry) begin
            nxt_idx[r] = idx[r] + 1'b1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  assign last = all_max |
    (ng[rd_bank] != 32'd0 && gen_cnt == ng[rd_bank] - 32'd1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gstate  <= G_IDLE;
      rd_bank <= 1'b0;
      gen_cnt <= '0;
      for (int r = 0; r < RANGES_MAX; r++) idx[r] <= '0;
    end else begin
      unique case (gstate)
        G_IDLE:
          if (rdy_now[rd_bank]) gstate <= G_LOAD;
        G_LOAD: begin
          for (int r = 0; r < RANGES_MAX; r++)
            idx[r] <= CW'(si[rd_bank][r]);
          gen_cnt <= '0;
          gstate  <= G_GEN;
        end
        G_GEN:
          if (rd_en) begin
            if (last) begin
              rd_bank <= ~rd_bank;
              gstate  <= rdy_now[~rd_bank] ? G_LOAD : G_IDLE;
            end else begin
              for (int r = 0; r < RANGES_MAX; r++)
                idx[r] <= nxt_idx[r];
              gen_cnt <= gen_cnt + 32'd1;
            end
          end
        default: gstate <= G_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    for (int r = 0; r < RANGES_MAX; r++)
      if (LW'(r) < nr[rd_bank])
        dout[(RANGES_MAX-1-r)*CHAR_BITS +: CHAR_BITS] =
          mem[rd_bank][r][idx[r]];
  end

  assign empty             = gstate != G_GEN;
  assign gen_end           = gstate == G_GEN && last;
  assign gen_id            = gen_cnt;
  assign pkt_id            = pid[rd_bank];
  assign word_len          = nr[rd_bank];
  assign err_word_gen_conf = cstate == C_ERROR;
  assign conf_full         = ready[wr_bank] | (cstate == C_ERROR);

endmodule

// File: tb/tb_word_gen_dbuf.sv
// Testbench for word_gen_dbuf: config table plus scoreboard of
// expected words built from a mixed-radix model of each config.
`timescale 1ns/1ps
module tb_word_gen_dbuf;

  localparam int CB = 7;
  localparam int RM = 8;
  localparam int DW = RM * CB;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic [7:0] din = '0;
  logic [15:0] inpkt_id = '0;
  logic wr_conf_en = 1'b0;
  logic rd_en = 1'b0;
  logic conf_full, empty, gen_end, err_word_gen_conf;
  logic [DW-1:0] dout;
  logic [3:0] word_len;
  logic [15:0] pkt_id;
  logic [31:0] gen_id;

  always #5 CLK = ~CLK;

  word_gen_dbuf dut (
    .CLK(CLK), .RESET_N(RESET_N), .din(din), .inpkt_id(inpkt_id),
    .wr_conf_en(wr_conf_en), .conf_full(conf_full), .rd_en(rd_en),
    .empty(empty), .dout(dout), .word_len(word_len), .pkt_id(pkt_id),
    .gen_id(gen_id), .gen_end(gen_end),
    .err_word_gen_conf(err_word_gen_conf)
  );

  typedef struct {
    logic [7:0] b;
    logic [15:0] id;
    bit magic;
  } wr_t;

  typedef struct {
    logic [DW-1:0] dout;
    logic [3:0] len;
    logic [15:0] pid;
    logic [31:0] gid;
    logic gend;
  } exp_t;

  typedef struct {
    int nr;
    logic [3:0][7:0] nc;
    logic [3:0][7:0] si;
    logic [3:0][3:0][7:0] ch;
    int ng;
    int pid;
    int exp_n;
    logic [DW-1:0] exp_last;
  } cfg_t;

  wr_t  wr_q[$];
  exp_t exp_q[$];
  int   gaps_q[$];
  cfg_t tbl[6];
  cfg_t big[3];

  int checks = 0, passes = 0;
  int nwords = 0, mags = 0, ends = 0, gap = 0, rd_mode = 0;
  bit in_gap = 0, mon_en = 0, saw_full = 0;
  logic [DW-1:0] last_dout = '0;

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endfunction

  function automatic logic [DW-1:0] wd(string s);
    logic [DW-1:0] d = '0;
    byte t;
    for (int i = 0; i < s.len(); i++) begin
      t = s[i];
      d[(RM-1-i)*CB +: CB] = t[CB-1:0];
    end
    return d;
  endfunction

  function automatic cfg_t mk(string r0, string r1, string r2,
                              int s0, int s1, int s2, int ng, int pid,
                              int en, string lw);
    cfg_t c;
    string rs[3];
    int ss[3];
    rs[0] = r0; rs[1] = r1; rs[2] = r2;
    ss[0] = s0; ss[1] = s1; ss[2] = s2;
    c.nr = 0; c.nc = '0; c.si = '0; c.ch = '0;
    for (int r = 0; r < 3; r++)
      if (rs[r].len() > 0) begin
        c.nr++;
        c.nc[r] = 8'(rs[r].len());
        c.si[r] = 8'(ss[r]);
        for (int k = 0; k < rs[r].len(); k++) c.ch[r][k] = rs[r][k];
      end
    c.ng = ng; c.pid = pid; c.exp_n = en; c.exp_last = wd(lw);
    return c;
  endfunction

  task automatic push_b(input logic [7:0] b, input logic [15:0] id,
                        input bit m);
    wr_t w;
    w.b = b; w.id = id; w.magic = m;
    wr_q.push_back(w);
  endtask

  task automatic push_cfg(input cfg_t c, input bit bad);
    int w[4];
    int tot, s, n, v, d;
    exp_t e;
    push_b(8'(c.nr), 16'(c.pid), 0);
    for (int r = 0; r < c.nr; r++) begin
      push_b(c.nc[r], 16'(c.pid), 0);
      push_b(c.si[r], 16'(c.pid), 0);
      for (int k = 0; k < int'(c.nc[r]); k++)
        push_b(c.ch[r][k], 16'(c.pid), 0);
    end
    for (int i = 0; i < 4; i++) push_b(8'(c.ng >> (8*i)), 16'(c.pid), 0);
    push_b(bad ? 8'hBA : 8'hBB, 16'(c.pid), !bad);
    if (bad) return;
    tot = 1;
    for (int r = c.nr - 1; r >= 0; r--) begin
      w[r] = tot;
      tot = tot * int'(c.nc[r]);
    end
    s = 0;
    for (int r = 0; r < c.nr; r++) s += int'(c.si[r]) * w[r];
    n = tot - s;
    if (c.ng != 0 && c.ng < n) n = c.ng;
    for (int k = 0; k < n; k++) begin
      v = s + k;
      e.dout = '0;
      for (int r = 0; r < c.nr; r++) begin
        d = (v / w[r]) % int'(c.nc[r]);
        e.dout[(RM-1-r)*CB +: CB] = c.ch[r][d][CB-1:0];
      end
      e.len = 4'(c.nr); e.pid = 16'(c.pid);
      e.gid = 32'(k); e.gend = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    wr_t w;
    exp_t e;
    @(negedge CLK);
    if (!RESET_N) begin
      wr_conf_en = 1'b0;
      rd_en = 1'b0;
      return;
    end
    if (mon_en) begin
      chk("conf_full_both_ready", conf_full, (mags - ends) == 2);
      if (conf_full) saw_full = 1;
    end
    if (wr_q.size() > 0 && !conf_full) begin
      w = wr_q.pop_front();
      din = w.b; inpkt_id = w.id; wr_conf_en = 1'b1;
      if (w.magic) mags++;
    end else begin
      wr_conf_en = 1'b0;
    end
    case (rd_mode)
      0: rd_en = 1'b0;
      1: rd_en = 1'b1;
      default: rd_en = 1'($urandom_range(0, 1));
    endcase
    if (empty) begin
      if (in_gap) gap++;
    end else begin
      if (in_gap) begin
        gaps_q.push_back(gap);
        in_gap = 0;
      end
      if (rd_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {dout, gen_id}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("word", {dout, word_len, pkt_id, gen_id, gen_end},
              {e.dout, e.len, e.pid, e.gid, e.gend});
          nwords++;
          last_dout = dout;
          if (e.gend) begin
            ends++;
            in_gap = 1;
            gap = 0;
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || wr_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_time", n < budget, 1);
  endtask

  task automatic wait_wr(input int budget);
    int n = 0;
    while (wr_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("writes_in_time", n < budget, 1);
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (nwords < target && n < budget) begin
      tick();
      n++;
    end
    chk("words_in_time", n < budget, 1);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_gen_id", gen_id, 0);
    chk("rst_conf_full", conf_full, 0);
    chk("rst_err", err_word_gen_conf, 0);
    chk("rst_outs", {gen_end, dout, word_len, pkt_id}, '0);
    wr_q.delete();
    exp_q.delete();
    mags = 0; ends = 0; in_gap = 0;
    wr_conf_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) tick();
    @(posedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  initial begin
    int nw0;
    tbl[0] = mk("ab", "xyz", "", 0, 0, 0, 0, 16'h0101, 6, "bz");
    tbl[1] = mk("ab", "xyz", "", 0, 1, 0, 0, 16'h0202, 5, "bz");
    tbl[2] = mk("ab", "xyz", "", 0, 0, 0, 4, 16'h0303, 4, "bx");
    tbl[3] = mk("ab", "xyz", "", 0, 0, 0, 1, 16'h0404, 1, "ax");
    tbl[4] = mk("pq", "r", "stu", 1, 0, 2, 0, 16'h0505, 1, "qru");
    tbl[5] = mk("abcd", "efg", "hi", 2, 1, 0, 7, 16'h0606, 7, "dfh");
    big[0] = mk("abcd", "efgh", "ijkl", 0, 0, 0, 0, 16'h1111, 64, "dhl");
    big[1] = mk("abcd", "efgh", "ijkl", 1, 2, 3, 50, 16'h2222, 37, "dhl");
    big[2] = mk("mnop", "qr", "stuv", 0, 0, 0, 0, 16'h3333, 32, "prv");

    repeat (3) tick();
    chk("in_rst_empty", empty, 1);
    chk("in_rst_outs", {conf_full, gen_end, err_word_gen_conf,
                        dout, word_len, pkt_id, gen_id}, '0);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    tick();
    chk("post_rst_empty", empty, 1);
    chk("post_rst_conf_full", conf_full, 0);

    for (int i = 0; i < 6; i++) begin
      rd_mode = (i == 1) ? 2 : 1;
      nw0 = nwords;
      push_cfg(tbl[i], 0);
      wait_drain(600);
      tick();
      chk("word_count", nwords - nw0, tbl[i].exp_n);
      chk("last_word", last_dout, tbl[i].exp_last);
      chk("idle_empty", empty, 1);
    end

    rd_mode = 1;
    in_gap = 0;
    gaps_q.delete();
    saw_full = 0;
    mon_en = 1;
    nw0 = nwords;
    for (int i = 0; i < 3; i++) push_cfg(big[i], 0);
    wait_drain(2000);
    mon_en = 0;
    chk("b2b_words", nwords - nw0, 133);
    chk("b2b_last", last_dout, big[2].exp_last);
    chk("b2b_saw_full", saw_full, 1);
    chk("b2b_gap_count", gaps_q.size(), 2);
    foreach (gaps_q[i]) chk("b2b_gap_len", gaps_q[i], 1);

    rd_mode = 0;
    push_cfg(tbl[0], 0);
    push_b(8'd9, 16'h0909, 0);
    wait_wr(200);
    repeat (2) tick();
    chk("nr9_err", err_word_gen_conf, 1);
    chk("nr9_full", conf_full, 1);
    chk("nr9_bank_held", empty, 0);
    rd_mode = 1;
    nw0 = nwords;
    wait_drain(200);
    tick();
    chk("nr9_words", nwords - nw0, 6);
    chk("nr9_last", last_dout, tbl[0].exp_last);
    chk("nr9_err_sticky", {err_word_gen_conf, conf_full}, 2'b11);
    pulse_reset();

    rd_mode = 0;
    push_cfg(tbl[2], 0);
    push_cfg(tbl[3], 1);
    wait_wr(200);
    repeat (2) tick();
    chk("magic_err", {err_word_gen_conf, conf_full}, 2'b11);
    rd_mode = 1;
    nw0 = nwords;
    wait_drain(200);
    tick();
    chk("magic_words", nwords - nw0, 4);
    chk("magic_last", last_dout, tbl[2].exp_last);
    pulse_reset();

    push_b(8'd1, 16'h0A0A, 0);
    push_b(8'd2, 16'h0A0A, 0);
    push_b(8'd2, 16'h0A0A, 0);
    wait_wr(50);
    repeat (2) tick();
    chk("start_idx_err", {err_word_gen_conf, conf_full, empty}, 3'b111);
    pulse_reset();

    rd_mode = 1;
    nw0 = nwords;
    push_cfg(big[0], 0);
    push_b(8'd2, 16'h9999, 0);
    push_b(8'd4, 16'h9999, 0);
    wait_words(nw0 + 10, 300);
    pulse_reset();
    nw0 = nwords;
    push_cfg(tbl[5], 0);
    wait_drain(300);
    tick();
    chk("fresh_words", nwords - nw0, 7);
    chk("fresh_last", last_dout, tbl[5].exp_last);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/word_gen_dbuf.md
# word_gen_dbuf

Double-buffered mask word generator: the next generation of the pkt_comm word generator. It accepts a byte-serial generator configuration into one of two banks while generating from the other, which removes the reconfiguration gap between consecutive word_gen packets. Generated words go to the downstream hash/compare pipeline through an empty/rd_en handshake. Range count, char width and charset depth are parameters.

## Interface
- CHAR_BITS, 7, bits per char; valid values are 7 and 8.
- RANGES_MAX, 8, maximum number of char ranges, which is also the maximum word length.
- CHARS_MAX, (CHAR_BITS==7 ? 96 : 224), maximum number of chars in one range.

- CLK  in  1  single clock for configuration and generation.
- RESET_N  in  1  asynchronous, active-low reset.
- din  in  8  configuration byte.
- inpkt_id  in  16  packet ID of the configuration being written; sampled on the num_ranges byte.
- wr_conf_en  in  1  din valid; ignored while conf_full=1.
- conf_full  out  1  no free bank, or configuration error.
- rd_en  in  1  consume the current word; ignored while empty=1.
- empty  out  1  low when dout, word_len, pkt_id, gen_id and gen_end are valid.
- dout  out  RANGES_MAX*CHAR_BITS  word; range 0 in the MS char; chars past word_len are 0.
- word_len  out  MSB(RANGES_MAX)+1  equal to num_ranges of the active bank.
- pkt_id  out  16  packet ID of the active bank.
- gen_id  out  32  index of the current word within its configuration.
- gen_end  out  1  the current word is the last word of its configuration.
- err_word_gen_conf  out  1  sticky configuration error flag.

## Operation
- Configuration stream format: num_ranges; then per range: num_chars, start_idx, chars[num_chars]; then num_generate as 4 bytes, LS byte first; then magic 0xBB.
- Configuration FSM states: NUM_RANGES, RANGE_NUM_CHARS, RANGE_START_IDX, RANGE_CHARS, NUM_GEN0..3, MAGIC, ERROR.
  - Each accepted byte advances the FSM.
  - RANGE_CHARS loops until num_chars bytes have been taken, then moves to the next range or to NUM_GEN0.
- The following go to ERROR:
  - num_ranges==0 or num_ranges>RANGES_MAX;
  - num_chars==0 or num_chars>CHARS_MAX;
  - start_idx>=num_chars;
  - magic!=0xBB.
- ERROR behaviour:
  - sets err_word_gen_conf and holds conf_full=1;
  - discards the partially written bank;
  - only RESET_N leaves ERROR;
  - a bank that was already ready still generates to completion.
- Banks:
  - Each bank holds a char RAM of RANGES_MAX x CHARS_MAX x CHAR_BITS, plus per-range num_chars and start_idx, num_ranges, num_generate and pkt_id.
  - Pointers wr_bank and rd_bank, and flags ready[1:0].
  - Valid magic sets ready[wr_bank] and toggles wr_bank.
  - conf_full = ready[wr_bank] | (state==ERROR).
- Generator FSM states: IDLE, LOAD, GEN.
  - IDLE goes to LOAD when ready[rd_bank]=1.
  - LOAD sets each range index to its start_idx and clears gen_id.
  - GEN drives empty=0.
- Word order is an odometer. The last range (num_ranges-1) is least significant. An index reaching num_chars-1 wraps to 0 and carries into the next range up.
- Last word is the earlier of:
  - every index equals num_chars-1;
  - num_generate!=0 and gen_id==num_generate-1.
- gen_end=1 on the last word.
- On rd_en with gen_end=1:
  - clear ready[rd_bank] and toggle rd_bank;
  - go to LOAD if the other bank is ready, else go to IDLE.
- gen_id increments on each consumed word. It wraps modulo 2^32, and the wrap does not affect termination.
- The writer only sets ready on a not-ready bank, and the reader only clears ready on its own ready bank. Set and clear in the same cycle on different bits are both applied.

## Timing
- Reset values:
  - conf_full=0, empty=1, gen_end=0, gen_id=0, pkt_id=0, dout=0, word_len=0, err_word_gen_conf=0;
  - ready=00, wr_bank=rd_bank=0;
  - configuration FSM in NUM_RANGES, generator FSM in IDLE.
- Configuration accepts 1 byte per cycle.
- Magic accepted at cycle t: ready set at t+1; conf_full updates at t+1.
- Generator idle:
  - LOAD at t+1;
  - first word (empty=0) at t+2.
- Throughput is one word per cycle while rd_en=1. Outputs change only after a cycle in which rd_en & ~empty.
- Bank switch: after the gen_end word is consumed, empty=1 for exactly 1 cycle (LOAD). The next configuration's first word follows.
- Outputs are read combinationally from the range index registers through async-read distributed RAM.
- RESET_N assertion mid-operation clears all state immediately. Banks are invalidated and a partially written configuration is lost.

## Test plan
- Config 2 ranges {a,b},{x,y,z}, start_idx 0/0, num_generate=0 -> words ax,ay,az,bx,by,bz; gen_id 0..5; gen_end only on bz; word_len=2.
- Same config with range 1 start_idx=1 -> ay,az,bx,by,bz (5 words); gen_end on bz.
- num_generate=4 -> ax,ay,az,bx; gen_end on bx. num_generate=1 -> single word ax with gen_end=1.
- Three configs written back-to-back while rd_en=1:
  - conf_full=1 while both banks are ready;
  - exactly 1 empty cycle between configurations;
  - pkt_id follows each configuration's inpkt_id.
- num_ranges=9 -> err_word_gen_conf=1 and conf_full=1. A previously ready bank still completes with gen_end. Bad magic behaves the same way.
- RESET_N pulse mid-GEN -> next cycle empty=1, gen_id=0, conf_full=0, err_word_gen_conf=0. A fresh config then generates from its start.
